// File: rtl/sb_n2b_conv.sv
// Float-to-decimal converter: IEEE-754 single to packed-BCD significand
// plus signed decimal exponent, rounded half away from zero.
module sb_n2b_conv #(
    parameter int DIGITS = 7,
    parameter int EXPW   = 7
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  finish,
    input  logic [31:0]           data,
    output logic [1:0]            instate,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [EXPW-1:0]       exp
);

    // value = a / b exactly; c7 tracks 10^DIGITS * b so the scaling
    // loop can bracket the quotient into [10^DIGITS, 10^(DIGITS+1)).
    localparam int W  = 180;
    localparam int QW = $clog2(10 ** (DIGITS + 1));
    localparam int BW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(QW);
    localparam logic [W-1:0]  TEN_D = W'(10 ** DIGITS);
    localparam logic [W-1:0]  ONE_W = W'(1);
    localparam logic [CW-1:0] LAST  = CW'(QW - 1);
    localparam logic [EXPW-1:0] ONE_E = EXPW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } st_t;

    typedef enum logic [2:0] {
        P_LOAD,
        P_SCALE,
        P_DIV,
        P_DAB,
        P_OUT
    } ph_t;

    st_t               st, st_n;
    ph_t               ph, ph_n;
    logic [30:0]       din, din_n;
    logic [W-1:0]      a, a_n, b, b_n, c7, c7_n;
    logic [QW-1:0]     q, q_n;
    logic [BW-1:0]     bw, bw_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [EXPW-1:0]   ex, ex_n, exr;
    logic [4*DIGITS-1:0] bcd_n, rnd;
    logic [EXPW-1:0]   exp_n;
    logic [BW-1:0]     adj;
    logic              cy, ge;

    logic [7:0]   ef;
    logic [22:0]  fr;
    logic [8:0]   ee, lsh, rsh;
    logic [W-1:0] mw, a10, b10, c10;
    logic         unused_sign;

    // The sign is irrelevant: only the magnitude is converted.
    assign unused_sign = data[31];

    assign ef  = din[30:23];
    assign fr  = din[22:0];
    assign mw  = W'({ef != 8'd0, fr});
    assign ee  = (ef == 8'd0) ? 9'd1 : {1'b0, ef};
    assign lsh = (ee >= 9'd150) ? ee - 9'd150 : 9'd0;
    assign rsh = (ee >= 9'd150) ? 9'd0 : 9'd150 - ee;
    assign a10 = (a << 3) + (a << 1);
    assign b10 = (b << 3) + (b << 1);
    assign c10 = (c7 << 3) + (c7 << 1);

    assign instate = st;

    function automatic logic [BW-1:0] dab_adj(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // State and datapath registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st  <= IDLE;
            ph  <= P_LOAD;
            din <= '0;
            a   <= '0;
            b   <= '0;
            c7  <= '0;
            q   <= '0;
            bw  <= '0;
            cnt <= '0;
            ex  <= '0;
            bcd <= '0;
            exp <= '0;
        end else begin
            st  <= st_n;
            ph  <= ph_n;
            din <= din_n;
            a   <= a_n;
            b   <= b_n;
            c7  <= c7_n;
            q   <= q_n;
            bw  <= bw_n;
            cnt <= cnt_n;
            ex  <= ex_n;
            bcd <= bcd_n;
            exp <= exp_n;
        end
    end

    // Next state: load, scale by 10, divide, double-dabble, round.
    always_comb begin
        st_n  = st;
        ph_n  = ph;
        din_n = din;
        a_n   = a;
        b_n   = b;
        c7_n  = c7;
        q_n   = q;
        bw_n  = bw;
        cnt_n = cnt;
        ex_n  = ex;
        bcd_n = bcd;
        exp_n = exp;
        adj   = dab_adj(bw);
        ge    = (a >= b);
        rnd   = bw[BW-1:4];
        cy    = (bw[3:0] >= 4'd5);
        exr   = ex;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (rnd[4*i +: 4] == 4'd9) begin
                    rnd[4*i +: 4] = 4'd0;
                end else begin
                    rnd[4*i +: 4] = rnd[4*i +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        if (cy) begin
            rnd = {4'd1, {(4*DIGITS-4){1'b0}}};
            exr = ex + ONE_E;
        end
        unique case (st)
            IDLE, DONE: begin
                if (finish) begin
                    din_n = data[30:0];
                    st_n  = BUSY;
                    ph_n  = P_LOAD;
                end
            end
            BUSY: begin
                unique case (ph)
                    P_LOAD: begin
                        if (ef == 8'hFF) begin
                            bcd_n = '1;
                            exp_n = '0;
                            st_n  = DONE;
                        end else if (ef == 8'd0 && fr == 23'd0) begin
                            bcd_n = '0;
                            exp_n = '0;
                            st_n  = DONE;
                        end else begin
                            a_n  = mw << lsh;
                            b_n  = ONE_W << rsh;
                            c7_n = TEN_D << rsh;
                            ex_n = EXPW'(DIGITS);
                            ph_n = P_SCALE;
                        end
                    end
                    P_SCALE: begin
                        if (a < c7) begin
                            a_n  = a10;
                            ex_n = ex - ONE_E;
                        end else if (a >= c10) begin
                            b_n  = b10;
                            c7_n = c10;
                            ex_n = ex + ONE_E;
                        end else begin
                            b_n   = b << (QW - 1);
                            q_n   = '0;
                            cnt_n = '0;
                            ph_n  = P_DIV;
                        end
                    end
                    P_DIV: begin
                        a_n   = ge ? a - b : a;
                        b_n   = b >> 1;
                        q_n   = {q[QW-2:0], ge};
                        cnt_n = cnt + CW'(1);
                        if (cnt == LAST) begin
                            cnt_n = '0;
                            bw_n  = '0;
                            ph_n  = P_DAB;
                        end
                    end
                    P_DAB: begin
                        bw_n  = {adj[BW-2:0], q[QW-1]};
                        q_n   = {q[QW-2:0], 1'b0};
                        cnt_n = cnt + CW'(1);
                        if (cnt == LAST) begin
                            cnt_n = '0;
                            ph_n  = P_OUT;
                        end
                    end
                    P_OUT: begin
                        bcd_n = rnd;
                        exp_n = exr;
                        st_n  = DONE;
                        ph_n  = P_LOAD;
                    end
                    default: ph_n = P_LOAD;
                endcase
            end
            default: st_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sb_n2b_conv.sv
// Scoreboard bench for sb_n2b_conv: directed operands with
// hand-computed BCD/exponent results, plus control corner cases.
module tb_sb_n2b_conv;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        finish = 1'b0;
    logic [31:0] data = '0;
    logic [1:0]  instate;
    logic [27:0] bcd;
    logic [6:0]  exp;

    sb_n2b_conv dut (
        .clk(clk),
        .rstn(rstn),
        .finish(finish),
        .data(data),
        .instate(instate),
        .bcd(bcd),
        .exp(exp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [27:0] bcd;
        logic [6:0]  exp;
    } exp_t;

    exp_t sb[$];
    exp_t vec[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [1:0] prev_st = 2'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every BUSY->DONE transition pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (prev_st == 2'd1 && instate == 2'd2) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {28'd0, bcd, exp}, 64'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_%h", e.din),
                      {29'd0, bcd, exp}, {29'd0, e.bcd, e.exp});
            end
        end
        prev_st = instate;
    end

    task automatic pulse(input logic [31:0] d);
        @(negedge clk);
        data = d;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check($sformatf("busy_after_start_%h", d), 64'(instate), 64'd1);
    endtask

    task automatic wait_done(input logic [31:0] d);
        int k;
        k = 0;
        while (instate != 2'd2 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("done_within_400_%h", d), 64'(instate), 64'd2);
    endtask

    task automatic conv(input logic [31:0] d, input logic [27:0] eb,
                        input logic [6:0] ee);
        sb.push_back('{d, eb, ee});
        pulse(d);
        wait_done(d);
    endtask

    initial begin
        vec.push_back('{32'h42D92E14, 28'h1085900, 7'h02});
        vec.push_back('{32'h3F800000, 28'h1000000, 7'h00});
        vec.push_back('{32'hBF800000, 28'h1000000, 7'h00});
        vec.push_back('{32'h3DCCCCCD, 28'h1000000, 7'h7F});
        vec.push_back('{32'h7F7FFFFF, 28'h3402823, 7'h26});
        vec.push_back('{32'h00000001, 28'h1401298, 7'h53});
        vec.push_back('{32'h00000000, 28'h0000000, 7'h00});
        vec.push_back('{32'h7F800000, 28'hFFFFFFF, 7'h00});
        vec.push_back('{32'h7FC00000, 28'hFFFFFFF, 7'h00});
        vec.push_back('{32'h4B189680, 28'h1000000, 7'h07});
        vec.push_back('{32'h4B18967F, 28'h9999999, 7'h06});
        vec.push_back('{32'h3F7FFFFF, 28'h9999999, 7'h7F});
        vec.push_back('{32'h00800000, 28'h1175494, 7'h5A});
        vec.push_back('{32'h40000000, 28'h2000000, 7'h00});

        #23;
        check("reset_instate", 64'(instate), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_exp", 64'(exp), 64'd0);
        rstn = 1'b1;

        foreach (vec[i]) conv(vec[i].din, vec[i].bcd, vec[i].exp);

        // finish while BUSY is ignored: result belongs to first operand
        sb.push_back('{32'h40490FDB, 28'h3141593, 7'h00});
        pulse(32'h40490FDB);
        repeat (5) @(negedge clk);
        data = 32'h7F800000;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        wait_done(32'h40490FDB);
        repeat (3) @(negedge clk);
        check("no_restart_after_busy_finish", 64'(instate), 64'd2);

        // finish in DONE restarts; old result held while BUSY
        sb.push_back('{32'h42D92E14, 28'h1085900, 7'h02});
        pulse(32'h42D92E14);
        repeat (10) @(negedge clk);
        check("hold_state", 64'(instate), 64'd1);
        check("hold_bcd", 64'(bcd), 64'h3141593);
        check("hold_exp", 64'(exp), 64'h00);
        wait_done(32'h42D92E14);

        // asynchronous reset mid-conversion
        pulse(32'h3F7FFFFF);
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_instate", 64'(instate), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_exp", 64'(exp), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        conv(32'h3F000000, 28'h5000000, 7'h7F);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sb_n2b_conv.md
Name: sb_n2b_conv

Overview:
- Multi-cycle converter from an IEEE-754 single-precision word to a 7-digit packed-BCD significand and a signed decimal exponent: |value| ≈ d6.d5d4d3d2d1d0 × 10^exp.
- Sits between the calculator's float datapath and the 7-segment/display formatter.
- Started by a one-cycle `finish` pulse from the upstream arithmetic unit.

Parameters:
- DIGITS, 7, number of BCD significand digits (bcd width = 4*DIGITS).
- EXPW, 7, width of the two's-complement decimal exponent.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- finish  input  1  start strobe; `data` is sampled on the rising edge where finish=1.
- data  input  32  IEEE-754 single-precision operand.
- instate  output  2  converter state: 0 IDLE, 1 BUSY, 2 DONE, 3 unused.
- bcd  output  28  packed BCD significand; [27:24] is the most significant digit.
- exp  output  7  decimal exponent, two's complement, range -64..63.

Behaviour:
- Interface: one clock (`clk`); reset `rstn` is asynchronous and active-low.
- Reset values: instate=IDLE, bcd=0, exp=0. Reset asserted mid-conversion aborts it and returns to IDLE.
- IDLE: finish=1 latches `data` and moves to BUSY.
- BUSY: finish is ignored. Completes within 400 cycles of the start edge, then moves to DONE. bcd/exp update only on the cycle of entering DONE.
- DONE: bcd/exp hold. finish=1 latches new `data` and moves to BUSY; the old bcd/exp stay valid until the new result is loaded.
- Sign bit data[31] is ignored; the magnitude is converted.
- Normal numbers: value = 1.f × 2^(e-127).
  - Result is the exact value rounded to 7 significant digits, round-half-away-from-zero.
  - First digit is nonzero.
  - If rounding carries (9999999.5… → 10000000), bcd = 1000000 and exp += 1.
- Denormals (e=0, f≠0): value = 0.f × 2^-126, converted by the same rule. Minimum exp = -45.
- Zero (e=0, f=0): bcd=0000000, exp=0.
- Inf/NaN (e=255): bcd=28'hFFFFFFF, exp=0.
- Implementation freedom: any exact method is allowed, e.g. a wide fixed-point register with iterative ×10/÷10 normalisation followed by double-dabble.
- Every output digit must be 0–9, except in the Inf/NaN code.

Test Plan:
- Reset, then finish pulse with data=32'h42D92E14 (108.58999634) -> instate goes 1 then 2 within 400 cycles; bcd=28'h1085900, exp=7'h02.
- data=32'h3F800000 (1.0) and 32'hBF800000 (-1.0) -> bcd=28'h1000000, exp=7'h00 for both.
- data=32'h3DCCCCCD (0.1) -> bcd=28'h1000000, exp=7'h7F (-1).
- Extremes:
  - data=32'h7F7FFFFF -> bcd=28'h3402823, exp=7'h26 (38).
  - data=32'h00000001 -> bcd=28'h1401298, exp=7'h53 (-45).
- Special values:
  - data=0 -> bcd=0, exp=0.
  - data=32'h7F800000 -> bcd=28'hFFFFFFF, exp=0.
  - data=32'h4B189680 (1e7) -> bcd=28'h1000000, exp=7'h07.
- Control corner cases:
  - finish pulsed again while BUSY -> ignored; the result matches the first operand.
  - rstn dropped mid-BUSY -> instate=0 and bcd=exp=0 immediately, without waiting for a clock edge.
  - finish in DONE -> new conversion starts; old outputs are held until it completes.
